// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequence engine.
//   - State encodings for the controller FSM.
//   - clog2_safe: counter width helper that never returns 0 bits.
package fib_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OP   = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_OP   = ST_OP,
    S_DONE = ST_DONE
  } state_t;

  // Width needed to hold values 0..value-1; a 1-bit counter is the minimum.
  function automatic int clog2_safe(input longint unsigned value);
    if (value <= 64'd2) begin
      return 32'sd1;
    end else begin
      return $clog2(value);
    end
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Synchronous rising-edge detector.
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   d      in  level input, already synchronous to clk
//   pulse  out registered one-cycle pulse for every 0->1 transition of d
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q_r;
  logic pulse_r;

  // Remember last level of d and flag a low-to-high change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q_r   <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      d_q_r   <= d;
      pulse_r <= d & ~d_q_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/fib_seq_engine.sv
// Parametrised Fibonacci FSMD feeding an 8-bit LED bank.
//   Holds the pair (t0,t1) = (F(k-1),F(k)); commands compute F(i) from scratch
//   (start), advance by i terms (skip) or advance by one term (next). A WIDTH
//   overflow stops the walk early and is flagged. The result is held in DONE
//   for HOLD_CYCLES cycles. A byte window over the result drives the LEDs.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, skip, next     level commands, accepted only in IDLE
//   i                     index / term count sampled on command accept
//   byte_step             level; each rising edge moves the LED window down
//   ready, busy           IDLE indicator / OP-or-DONE indicator
//   done_tick             one-cycle pulse on DONE entry
//   overflow              last command ran into WIDTH overflow
//   result                current term t1
//   byte_idx, led         selected byte and its registered value
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int N_W         = 8,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         skip,
  input  logic                         next,
  input  logic [N_W-1:0]               i,
  input  logic                         byte_step,
  output logic                         ready,
  output logic                         busy,
  output logic                         done_tick,
  output logic                         overflow,
  output logic [WIDTH-1:0]             result,
  output logic [$clog2(WIDTH/8)-1:0]   byte_idx,
  output logic [7:0]                   led
);

  localparam int NB = WIDTH / 8;
  localparam int BW = $clog2(NB);
  localparam int HW = clog2_safe(longint'(HOLD_CYCLES) + 64'sd1);
  localparam logic [BW-1:0] IDX_MAX   = BW'(NB - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] t0_r, t0_s;
  logic [WIDTH-1:0] t1_r, t1_s;
  logic [N_W-1:0]   n_r, n_s;
  logic [HW-1:0]    hold_r, hold_s;
  logic             ovf_r, ovf_s;
  logic             tick_r, tick_s;
  logic [WIDTH:0]   sum_s;
  logic [BW-1:0]    byte_idx_r;
  logic [7:0]       led_r;
  logic             step_pulse_s;

  // Next-state and datapath decisions for the controller.
  always_comb begin
    state_s = state_r;
    t0_s    = t0_r;
    t1_s    = t1_r;
    n_s     = n_r;
    hold_s  = hold_r;
    ovf_s   = ovf_r;
    tick_s  = 1'b0;
    sum_s   = {1'b0, t0_r} + {1'b0, t1_r};
    case (state_r)
      S_IDLE: begin
        if (start) begin
          t0_s    = WIDTH'(1);
          t1_s    = {WIDTH{1'b0}};
          n_s     = i;
          ovf_s   = 1'b0;
          state_s = S_OP;
        end else if (skip) begin
          n_s     = i;
          ovf_s   = 1'b0;
          state_s = S_OP;
        end else if (next) begin
          n_s     = N_W'(1);
          ovf_s   = 1'b0;
          state_s = S_OP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_OP: begin
        if (n_r == {N_W{1'b0}}) begin
          state_s = S_DONE;
          hold_s  = {HW{1'b0}};
          tick_s  = 1'b1;
        end else if (sum_s[WIDTH]) begin
          // Next term does not fit: keep the last valid pair and stop.
          ovf_s   = 1'b1;
          state_s = S_DONE;
          hold_s  = {HW{1'b0}};
          tick_s  = 1'b1;
        end else begin
          t0_s = t1_r;
          t1_s = sum_s[WIDTH-1:0];
          n_s  = n_r - N_W'(1);
        end
      end
      S_DONE: begin
        if (hold_r == HOLD_LAST) begin
          state_s = S_IDLE;
          hold_s  = {HW{1'b0}};
        end else begin
          hold_s = hold_r + HW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Controller state and term pair registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      t0_r    <= WIDTH'(1);
      t1_r    <= {WIDTH{1'b0}};
      n_r     <= {N_W{1'b0}};
      hold_r  <= {HW{1'b0}};
      ovf_r   <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      t0_r    <= t0_s;
      t1_r    <= t1_s;
      n_r     <= n_s;
      hold_r  <= hold_s;
      ovf_r   <= ovf_s;
      tick_r  <= tick_s;
    end
  end

  edge_pulse u_step_edge (
    .clk   (clk),
    .reset (reset),
    .d     (byte_step),
    .pulse (step_pulse_s)
  );

  // LED window: walks from MS byte towards LS byte, wrapping around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx_r <= IDX_MAX;
    end else if (step_pulse_s) begin
      if (byte_idx_r == {BW{1'b0}}) begin
        byte_idx_r <= IDX_MAX;
      end else begin
        byte_idx_r <= byte_idx_r - BW'(1);
      end
    end else begin
      byte_idx_r <= byte_idx_r;
    end
  end

  // LED byte follows the selected result byte one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r <= 8'h00;
    end else begin
      led_r <= t1_r[{byte_idx_r, 3'b000} +: 8];
    end
  end

  assign ready     = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);
  assign done_tick = tick_r;
  assign overflow  = ovf_r;
  assign result    = t1_r;
  assign byte_idx  = byte_idx_r;
  assign led       = led_r;

endmodule

// File: tb/tb_fib_seq_engine.sv
// Self-checking bench for fib_seq_engine (WIDTH=64, HOLD_CYCLES=4).
module tb_fib_seq_engine;

  localparam int WIDTH = 64;
  localparam int N_W   = 8;
  localparam int HOLD  = 4;
  localparam logic [64:0] LIM = {1'b1, 64'd0};

  logic clk = 1'b0;
  logic reset, start, skip, next, byte_step;
  logic [N_W-1:0] i;
  logic ready, busy, done_tick, overflow;
  logic [WIDTH-1:0] result;
  logic [2:0] byte_idx;
  logic [7:0] led;

  fib_seq_engine #(.WIDTH(WIDTH), .N_W(N_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .skip(skip), .next(next),
    .i(i), .byte_step(byte_step), .ready(ready), .busy(busy),
    .done_tick(done_tick), .overflow(overflow), .result(result),
    .byte_idx(byte_idx), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: term index k, overflow flag, and cycle numbers of the
  // DONE entry and the return to IDLE for the last accepted command.
  int cyc, m_k, m_done_at, m_rel_at, m_edges, m_e1;
  bit m_ovf, m_prev_step;
  int cmd_base, cmd_cnt, cmd_m;

  function automatic logic [64:0] fib65(input int k);
    logic [64:0] a, b, c;
    a = 65'd1;
    b = 65'd0;
    for (int j = 0; j < k; j++) begin
      c = a + b;
      a = b;
      b = c;
    end
    return b;
  endfunction

  // Number of terms that can be advanced from F(kb) before exceeding 64 bits.
  function automatic int ok_steps(input int kb, input int n);
    int m;
    m = 0;
    while (m < n && fib65(kb + m + 1) < LIM) m++;
    return m;
  endfunction

  always_comb begin
    cmd_base = start ? 0 : m_k;
    cmd_cnt  = (start || skip) ? int'(i) : 1;
    cmd_m    = ok_steps(cmd_base, cmd_cnt);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0; m_k <= 0; m_ovf <= 1'b0; m_done_at <= -100; m_rel_at <= 0;
      m_edges <= 0; m_e1 <= 0; m_prev_step <= 1'b0;
    end else begin
      if (cyc >= m_rel_at && (start || skip || next)) begin
        m_k       <= cmd_base + cmd_m;
        m_ovf     <= (cmd_m < cmd_cnt);
        m_done_at <= cyc + cmd_m + 2;
        m_rel_at  <= cyc + cmd_m + 2 + HOLD;
      end
      if (byte_step && !m_prev_step) m_edges <= m_edges + 1;
      m_e1        <= m_edges;
      m_prev_step <= byte_step;
      cyc         <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  bit prev_valid = 1'b0;
  logic [63:0] prev_res;
  int prev_idx;

  task automatic cmp_cycle();
    logic [64:0] f;
    logic [63:0] cur;
    bit op;
    int eidx;
    if (reset) begin
      prev_valid = 1'b0;
      return;
    end
    op   = (cyc < m_done_at);
    f    = fib65(m_k);
    cur  = f[63:0];
    eidx = (7 - (m_e1 % 8) + 8) % 8;
    chk("ready", ready, (cyc >= m_rel_at));
    chk("busy", busy, (cyc < m_rel_at));
    chk("done_tick", done_tick, (cyc == m_done_at));
    chk("overflow", overflow, op ? 1'b0 : m_ovf);
    if (!op) chk("result", result, cur);
    chk("byte_idx", byte_idx, eidx);
    if (prev_valid) chk("led", led, prev_res[prev_idx*8 +: 8]);
    prev_valid = !op;
    prev_res   = cur;
    prev_idx   = eidx;
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic cmd(input bit s, input bit k, input bit x, input int iv, output int c0);
    start = s; skip = k; next = x; i = N_W'(iv);
    c0 = cyc;
    tick();
    start = 1'b0; skip = 1'b0; next = 1'b0;
  endtask

  task automatic wait_done();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (done_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++; fails++;
      $display("FAIL wait_done: no done_tick within 400 cycles");
    end
  endtask

  task automatic wait_ready();
    bit found;
    found = (ready === 1'b1);
    for (int n = 0; n < 400 && !found; n++) begin
      tick();
      if (ready === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++; fails++;
      $display("FAIL wait_ready: ready not seen within 400 cycles");
    end
  endtask

  task automatic run_cmd(input bit s, input bit k, input bit x, input int iv, output int c0);
    wait_ready();
    cmd(s, k, x, iv, c0);
    wait_done();
  endtask

  int c0;

  initial begin
    reset = 1'b1; start = 1'b0; skip = 1'b0; next = 1'b0; i = '0; byte_step = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 64'd0);
    chk("rst_byte_idx", byte_idx, 3'd7);
    chk("rst_led", led, 8'h00);
    reset = 1'b0;
    tick();

    // F(10): DONE exactly 12 cycles after accept, IDLE again 4 cycles later.
    run_cmd(1'b1, 1'b0, 1'b0, 10, c0);
    chk("t1_latency", cyc, c0 + 12);
    chk("t1_result", result, 64'd55);
    repeat (3) tick();
    chk("t1_hold_ready", ready, 1'b0);
    tick();
    chk("t1_release_ready", ready, 1'b1);

    // start 0, next, next -> 0, 1, 1
    run_cmd(1'b1, 1'b0, 1'b0, 0, c0);
    chk("t2_f0", result, 64'd0);
    run_cmd(1'b0, 1'b0, 1'b1, 0, c0);
    chk("t2_f1", result, 64'd1);
    run_cmd(1'b0, 1'b0, 1'b1, 0, c0);
    chk("t2_f2", result, 64'd1);
    chk("t2_ovf", overflow, 1'b0);

    // Largest 64-bit term, then overflow on the next step.
    run_cmd(1'b1, 1'b0, 1'b0, 93, c0);
    chk("t3_f93", result, 64'd12200160415121876738);
    chk("t3_ovf0", overflow, 1'b0);
    run_cmd(1'b0, 1'b0, 1'b1, 0, c0);
    chk("t3_ovf1", overflow, 1'b1);
    chk("t3_hold", result, 64'd12200160415121876738);
    chk("t3_early", cyc, c0 + 2);

    // skip and priority
    run_cmd(1'b1, 1'b0, 1'b0, 20, c0);
    chk("t4_f20", result, 64'd6765);
    run_cmd(1'b0, 1'b1, 1'b0, 5, c0);
    chk("t4_f25", result, 64'd75025);
    run_cmd(1'b1, 1'b1, 1'b0, 7, c0);
    chk("t4_prio", result, 64'd13);
    next = 1'b1;              // ignored while in DONE
    tick();
    next = 1'b0;
    wait_ready();
    chk("t4_ignored", result, 64'd13);

    // Byte window: 7 edges bring the LS byte (0x0d) onto the LEDs.
    for (int e = 0; e < 7; e++) begin
      byte_step = 1'b1; tick(); tick();
      byte_step = 1'b0; tick(); tick();
    end
    tick();
    chk("t5_idx0", byte_idx, 3'd0);
    chk("t5_led", led, 8'h0d);
    byte_step = 1'b1;
    repeat (6) tick();
    byte_step = 1'b0;
    repeat (3) tick();
    chk("t5_wrap", byte_idx, 3'd7);
    chk("t5_led_wrap", led, 8'h00);

    // Random commands (also while busy) and random window steps.
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      start = (r == 0);
      skip  = (r == 1);
      next  = (r == 2) || (r == 3);
      i     = N_W'($urandom_range(0, 100));
      if ($urandom_range(0, 3) == 0) byte_step = ~byte_step;
      tick();
    end
    start = 1'b0; skip = 1'b0; next = 1'b0; byte_step = 1'b0;
    wait_ready();

    // Reset in the middle of OP.
    wait_ready();
    cmd(1'b1, 1'b0, 1'b0, 50, c0);
    repeat (19) tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_ready", ready, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done_tick, 1'b0);
    chk("t6_ovf", overflow, 1'b0);
    chk("t6_led", led, 8'h00);
    chk("t6_idx", byte_idx, 3'd7);
    chk("t6_result", result, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();
    run_cmd(1'b1, 1'b0, 1'b0, 7, c0);
    chk("t6_f7", result, 64'd13);
    wait_ready();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
